// File: rtl/div_iter_ctrl_if.sv
// Handshake and data bundle between the FP divide/sqrt controller and the
// iterative mantissa divider.
interface div_iter_ctrl_if #(
    parameter int WIDTH = 24
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             ready;
    logic             busy;
    logic             done;
    logic             dz;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, abort, dividend, divisor,
        input  ready, busy, done, dz, quotient, remainder
    );

    modport slave (
        input  start, abort, dividend, divisor,
        output ready, busy, done, dz, quotient, remainder
    );
endinterface

// File: rtl/div_iter_ctrl.sv
// Non-restoring iterative unsigned divider: one shift-add/subtract step per
// clock, final remainder correction in FIX, divide-by-zero short path.
module div_iter_ctrl #(
    parameter int WIDTH = 24,
    parameter int CNT_W = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    div_iter_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} stateT;

    stateT            state;
    logic [WIDTH:0]   aReg;
    logic [WIDTH:0]   bReg;
    logic [WIDTH-1:0] qReg;
    logic [CNT_W-1:0] cntReg;
    logic             dzPendReg;
    logic [WIDTH-1:0] dzDividendReg;

    logic             readyReg;
    logic             busyReg;
    logic             doneReg;
    logic             dzReg;
    logic [WIDTH-1:0] quotientReg;
    logic [WIDTH-1:0] remainderReg;

    logic [WIDTH:0]   aShift;
    logic [WIDTH:0]   aStep;
    logic [WIDTH-1:0] remFix;

    // Only the low WIDTH bits of the corrected remainder are kept, so the
    // correction add is done at WIDTH bits.
    always_comb begin
        aShift = {aReg[WIDTH-1:0], qReg[WIDTH-1]};
        aStep  = aReg[WIDTH] ? (aShift + bReg) : (aShift - bReg);
        remFix = aReg[WIDTH] ? (aReg[WIDTH-1:0] + bReg[WIDTH-1:0]) : aReg[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            aReg          <= '0;
            bReg          <= '0;
            qReg          <= '0;
            cntReg        <= '0;
            dzPendReg     <= 1'b0;
            dzDividendReg <= '0;
            readyReg      <= 1'b1;
            busyReg       <= 1'b0;
            doneReg       <= 1'b0;
            dzReg         <= 1'b0;
            quotientReg   <= '0;
            remainderReg  <= '0;
        end else begin
            doneReg <= 1'b0;
            unique case (state)
                IDLE: begin
                    // A zero-divisor request completes on the edge after its
                    // accept; ready stays high so a new request may overlap.
                    dzPendReg <= 1'b0;
                    if (dzPendReg) begin
                        doneReg      <= 1'b1;
                        dzReg        <= 1'b1;
                        quotientReg  <= '1;
                        remainderReg <= dzDividendReg;
                    end
                    if (bus.start) begin
                        if (bus.divisor == '0) begin
                            dzPendReg     <= 1'b1;
                            dzDividendReg <= bus.dividend;
                        end else begin
                            aReg     <= '0;
                            qReg     <= bus.dividend;
                            bReg     <= {1'b0, bus.divisor};
                            cntReg   <= '0;
                            state    <= RUN;
                            readyReg <= 1'b0;
                            busyReg  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        state    <= IDLE;
                        readyReg <= 1'b1;
                        busyReg  <= 1'b0;
                    end else begin
                        aReg   <= aStep;
                        qReg   <= {qReg[WIDTH-2:0], ~aStep[WIDTH]};
                        cntReg <= cntReg + 1'b1;
                        if (cntReg == CNT_W'(WIDTH - 1)) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    state    <= IDLE;
                    readyReg <= 1'b1;
                    busyReg  <= 1'b0;
                    if (!bus.abort) begin
                        doneReg      <= 1'b1;
                        dzReg        <= 1'b0;
                        quotientReg  <= qReg;
                        remainderReg <= remFix;
                    end
                end
                default: begin
                    state    <= IDLE;
                    readyReg <= 1'b1;
                    busyReg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready     = readyReg;
    assign bus.busy      = busyReg;
    assign bus.done      = doneReg;
    assign bus.dz        = dzReg;
    assign bus.quotient  = quotientReg;
    assign bus.remainder = remainderReg;
endmodule

// File: tb/tb_div_iter_ctrl.sv
// Bench for div_iter_ctrl: directed cases with literal results plus a
// randomized run, all compared each cycle against an arithmetic model.
module tb_div_iter_ctrl;
    localparam int W = 24;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    div_iter_ctrl_if #(.WIDTH(W)) bus ();

    div_iter_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: an operation finishes a fixed number of edges after
    // its accept; results come from integer / and %.
    int           mCyc = 0;
    bit           mBusy = 0, mDzPend = 0, mDone = 0, mDz = 0;
    logic [W-1:0] mQ = '0, mR = '0, mPendQ = '0, mPendR = '0, mDzDiv = '0;
    int           mFinish = 0;
    int           mDoneCnt = 0;
    int           dutDoneCnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (clk) mCyc = mCyc + 1;
        if (!rst_n) begin
            mBusy = 0; mDzPend = 0; mDone = 0; mDz = 0; mQ = '0; mR = '0;
        end else begin
            mDone = 0;
            if (mBusy) begin
                if (bus.abort) begin
                    mBusy = 0;
                end else if (mCyc == mFinish) begin
                    mBusy = 0; mDone = 1; mDz = 0; mQ = mPendQ; mR = mPendR;
                end
            end else begin
                if (mDzPend) begin
                    mDone = 1; mDz = 1; mQ = '1; mR = mDzDiv; mDzPend = 0;
                end
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        mDzPend = 1; mDzDiv = bus.dividend;
                    end else begin
                        mBusy = 1; mFinish = mCyc + W + 1;
                        mPendQ = bus.dividend / bus.divisor;
                        mPendR = bus.dividend % bus.divisor;
                    end
                end
            end
            if (mDone) mDoneCnt++;
        end
    end

    always @(negedge clk) begin
        checks++;
        if ({bus.ready, bus.busy, bus.done, bus.dz, bus.quotient, bus.remainder} !==
            {!mBusy, mBusy, mDone, mDz, mQ, mR}) begin
            errors++;
            $display("FAIL model_cmp cyc=%0d actual rdy=%b busy=%b done=%b dz=%b q=%h r=%h required rdy=%b busy=%b done=%b dz=%b q=%h r=%h",
                     mCyc, bus.ready, bus.busy, bus.done, bus.dz, bus.quotient, bus.remainder,
                     !mBusy, mBusy, mDone, mDz, mQ, mR);
        end
        if (bus.done === 1'b1) dutDoneCnt++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic startOp(input logic [W-1:0] a, input logic [W-1:0] b, output int acc);
        int n = 0;
        while (bus.ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {63'd0, bus.ready}, 64'd1);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(negedge clk);
        acc          = mCyc;
        bus.start    = 1'b0;
        bus.dividend = W'($urandom);
        bus.divisor  = W'($urandom);
    endtask

    task automatic waitDone(input int acc, input int expLat, input logic [W-1:0] eq,
                            input logic [W-1:0] er, input bit edz, input string nm);
        int n = 0;
        while (bus.done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_lat"}, 64'(mCyc - acc), 64'(expLat));
        chk({nm, "_q"}, 64'(bus.quotient), 64'(eq));
        chk({nm, "_r"}, 64'(bus.remainder), 64'(er));
        chk({nm, "_dz"}, {63'd0, bus.dz}, {63'd0, edz});
    endtask

    initial begin
        int acc;
        int d0;
        logic [W-1:0] a, b;
        bus.start = 1'b0; bus.abort = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {63'd0, bus.ready}, 64'd1);
        chk("rst_q", 64'(bus.quotient), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        startOp(24'd100, 24'd7, acc);
        waitDone(acc, 25, 24'd14, 24'd2, 1'b0, "div100_7");
        startOp(24'hFFFFFF, 24'h000001, acc);
        waitDone(acc, 25, 24'hFFFFFF, 24'd0, 1'b0, "divmax_1");
        startOp(24'h000005, 24'hFFFFFF, acc);
        waitDone(acc, 25, 24'd0, 24'd5, 1'b0, "div5_max");
        startOp(24'h123456, 24'd0, acc);
        waitDone(acc, 1, 24'hFFFFFF, 24'h123456, 1'b1, "divzero");
        startOp(24'hC00000, 24'h800000, acc);
        waitDone(acc, 25, 24'd1, 24'h400000, 1'b0, "after_dz");

        // A start in the middle of an operation must be ignored.
        startOp(24'd100, 24'd7, acc);
        while (mCyc - acc < 10) @(negedge clk);
        bus.start = 1'b1; bus.dividend = 24'd999; bus.divisor = 24'd4;
        @(negedge clk);
        bus.start = 1'b0;
        waitDone(acc, 25, 24'd14, 24'd2, 1'b0, "ignored_start");
        startOp(24'hC00000, 24'h800000, acc);
        waitDone(acc, 25, 24'd1, 24'h400000, 1'b0, "prior");

        // Abort mid-run, then start again in the first ready cycle.
        startOp(24'd200, 24'd9, acc);
        while (mCyc - acc < 12) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_ready", {63'd0, bus.ready}, 64'd1);
        chk("abort_done", {63'd0, bus.done}, 64'd0);
        chk("abort_keep_q", 64'(bus.quotient), 64'd1);
        chk("abort_keep_r", 64'(bus.remainder), 64'h400000);
        startOp(24'd1000, 24'd33, acc);
        waitDone(acc, 25, 24'd30, 24'd10, 1'b0, "after_abort");

        // Abort arriving on the completion edge wins.
        startOp(24'd77, 24'd5, acc);
        while (mCyc - acc < 24) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_fix_done", {63'd0, bus.done}, 64'd0);
        repeat (3) @(negedge clk);
        chk("abort_fix_keep_q", 64'(bus.quotient), 64'd30);

        // Abort while idle does not block a start.
        bus.abort = 1'b1;
        startOp(24'd50, 24'd6, acc);
        bus.abort = 1'b0;
        waitDone(acc, 25, 24'd8, 24'd2, 1'b0, "idle_abort");

        // Start held high: new operands on each ready cycle.
        bus.start = 1'b1;
        for (int i = 0; i < 82; i++) begin
            if (bus.ready === 1'b1) begin
                bus.dividend = W'($urandom);
                bus.divisor  = W'($urandom_range(1, 24'hFFFFFF));
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        repeat (30) @(negedge clk);

        // Reset in the middle of a run.
        startOp(24'd100, 24'd7, acc);
        while (mCyc - acc < 5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", {63'd0, bus.ready}, 64'd1);
        chk("arst_busy", {63'd0, bus.busy}, 64'd0);
        chk("arst_q", 64'(bus.quotient), 64'd0);
        chk("arst_r", 64'(bus.remainder), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        d0 = dutDoneCnt;
        repeat (30) @(negedge clk);
        chk("arst_no_done", 64'(dutDoneCnt - d0), 64'd0);

        // Randomized regression.
        for (int i = 0; i < 36000; i++) begin
            int sel;
            sel = int'($urandom_range(0, 15));
            a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : W'($urandom);
            if (sel == 0)      b = '0;
            else if (sel < 4)  b = W'($urandom_range(1, 255));
            else if (sel == 4) b = (a == '0) ? W'(1) : a;
            else               b = W'($urandom);
            bus.dividend = a;
            bus.divisor  = b;
            bus.start    = ($urandom_range(0, 7) != 0);
            bus.abort    = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (30) @(negedge clk);
        chk("done_total", 64'(dutDoneCnt), 64'(mDoneCnt));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
